fwd_scoreboard: RTL and testbench



---
 rtl/fwd_scoreboard_if.sv | 48 ++++
 rtl/fwd_scoreboard.sv | 110 +++++++++++
 tb/tb_fwd_scoreboard.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_if.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard_if
//   Bundles the EX-stage side of the forwarding/interlock unit.
//   master : EX stage / pipeline control (drives the EX instruction fields,
//            flush and counter clear; consumes forwarding selects and stall)
//   slave  : fwd_scoreboard
//
//   ex_valid        EX holds a real instruction
//   ex_rs1/ex_rs2   EX source registers
//   ex_rd, ex_we    EX destination register and its write enable
//   ex_kind         00 ALU, 01 LOAD, 10 MUL, 11 ALU
//   flush           kill the EX instruction
//   cnt_clr         synchronous clear of stall_cnt
//   fwd_a/fwd_b     0 = register file, k = forward from pipeline register Pk
//   stall           hold PC/IF/ID/EX, bubble into P1
//   stall_cnt       saturating stall-cycle counter
// -----------------------------------------------------------------------------
interface fwd_scoreboard_if #(
    parameter int NREG  = 32,
    parameter int DEPTH = 4,
    parameter int CW    = 16
);
    localparam int AW = $clog2(NREG);
    localparam int SW = $clog2(DEPTH + 1);

    logic          ex_valid;
    logic [AW-1:0] ex_rs1;
    logic [AW-1:0] ex_rs2;
    logic [AW-1:0] ex_rd;
    logic          ex_we;
    logic [1:0]    ex_kind;
    logic          flush;
    logic          cnt_clr;
    logic [SW-1:0] fwd_a;
    logic [SW-1:0] fwd_b;
    logic          stall;
    logic [CW-1:0] stall_cnt;

    modport master (
        output ex_valid, ex_rs1, ex_rs2, ex_rd, ex_we, ex_kind, flush, cnt_clr,
        input  fwd_a, fwd_b, stall, stall_cnt
    );

    modport slave (
        input  ex_valid, ex_rs1, ex_rs2, ex_rd, ex_we, ex_kind, flush, cnt_clr,
        output fwd_a, fwd_b, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard
//   Forwarding and interlock unit beside the EX stage. Tracks the destination
//   registers of in-flight instructions across DEPTH post-EX pipeline
//   registers (P1 = EX/MEM .. PDEPTH), selects the youngest matching producer
//   as the operand source, and stalls when that producer's result is not yet
//   available. Keeps a saturating stall-cycle counter.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (clears all entries and counter)
//     bus    fwd_scoreboard_if.slave (EX instruction in, fwd selects/stall out)
//
//   The interface instance must be built with the same NREG/DEPTH/CW values.
// -----------------------------------------------------------------------------
module fwd_scoreboard #(
    parameter int NREG    = 32,
    parameter int DEPTH   = 4,
    parameter int MUL_LAT = 4,
    parameter int CW      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_scoreboard_if.slave   bus
);
    localparam int AW = $clog2(NREG);
    localparam int SW = $clog2(DEPTH + 1);

    // Pipeline register entries, index i holds position P(i+1).
    logic          r_v     [DEPTH];
    logic [AW-1:0] r_rd    [DEPTH];
    logic          r_we    [DEPTH];
    logic [SW-1:0] r_avail [DEPTH];
    logic [CW-1:0] r_cnt;

    logic [SW-1:0] w_fwd_a;
    logic [SW-1:0] w_fwd_b;
    logic          w_haz_a;
    logic          w_haz_b;
    logic          w_stall;
    logic          w_issue;
    logic [SW-1:0] w_avail_in;

    // Returns {hazard, fwd}. Walks from the oldest position to the youngest
    // so the last hit (smallest p) decides, regardless of older ready entries.
    function automatic logic [SW:0] f_match(input logic [AW-1:0] rs);
        logic [SW:0] res;
        res = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (r_v[DEPTH-1-k] && r_we[DEPTH-1-k] &&
                (r_rd[DEPTH-1-k] != '0) && (r_rd[DEPTH-1-k] == rs)) begin
                if (r_avail[DEPTH-1-k] <= SW'(DEPTH - k))
                    res = {1'b0, SW'(DEPTH - k)};
                else
                    res = {1'b1, SW'(0)};
            end
        end
        return res;
    endfunction

    always_comb begin
        {w_haz_a, w_fwd_a} = f_match(bus.ex_rs1);
        {w_haz_b, w_fwd_b} = f_match(bus.ex_rs2);
    end

    assign w_stall = bus.ex_valid && !bus.flush && (w_haz_a || w_haz_b);
    assign w_issue = bus.ex_valid && !w_stall && !bus.flush;

    // Cycle position at which the EX result first becomes forwardable.
    always_comb begin
        unique case (bus.ex_kind)
            2'b01:   w_avail_in = SW'(2);
            2'b10:   w_avail_in = SW'(MUL_LAT);
            default: w_avail_in = SW'(1);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_v[i]     <= 1'b0;
                r_rd[i]    <= '0;
                r_we[i]    <= 1'b0;
                r_avail[i] <= '0;
            end
            r_cnt <= '0;
        end else begin
            r_v[0]     <= w_issue;
            r_rd[0]    <= bus.ex_rd;
            r_we[0]    <= bus.ex_we;
            r_avail[0] <= w_avail_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_v[i]     <= r_v[i-1];
                r_rd[i]    <= r_rd[i-1];
                r_we[i]    <= r_we[i-1];
                r_avail[i] <= r_avail[i-1];
            end
            if (bus.cnt_clr)
                r_cnt <= '0;
            else if (w_stall && (r_cnt != '1))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.fwd_a     = w_fwd_a;
    assign bus.fwd_b     = w_fwd_b;
    assign bus.stall     = w_stall;
    assign bus.stall_cnt = r_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;
    localparam int NREG    = 32;
    localparam int DEPTH   = 4;
    localparam int MUL_LAT = 4;
    localparam int CW      = 4;
    localparam logic [1:0] K_ALU = 2'b00;
    localparam logic [1:0] K_LD  = 2'b01;
    localparam logic [1:0] K_MUL = 2'b10;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    fwd_scoreboard_if #(.NREG(NREG), .DEPTH(DEPTH), .CW(CW)) bus ();

    fwd_scoreboard #(.NREG(NREG), .DEPTH(DEPTH), .MUL_LAT(MUL_LAT), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we, input logic [1:0] kind);
        bus.ex_valid = v;
        bus.ex_rs1   = rs1;
        bus.ex_rs2   = rs2;
        bus.ex_rd    = rd;
        bus.ex_we    = we;
        bus.ex_kind  = kind;
    endtask

    task automatic drain();
        bus.flush   = 1'b0;
        bus.cnt_clr = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, K_ALU);
        repeat (DEPTH) step();
    endtask

    task automatic clear_cnt();
        bus.cnt_clr = 1'b1;
        step();
        bus.cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.cnt_clr = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, K_ALU);
        #3;
        n_total++; if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %0d required 0", bus.stall); else n_pass++;
        n_total++; if (bus.fwd_a !== 3'd0) $display("FAIL reset_fwd_a: got %0d required 0", bus.fwd_a); else n_pass++;
        n_total++; if (bus.stall_cnt !== 4'd0) $display("FAIL reset_cnt: got %0d required 0", bus.stall_cnt); else n_pass++;
        step();
        rst_n = 1'b1;
        drain();
    endtask

    task automatic test_alu_fwd();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, K_ALU);
        step();
        drive(1'b1, 5'd5, 5'd6, 5'd1, 1'b1, K_ALU);
        #1;
        n_total++; if (bus.fwd_a !== 3'd1) $display("FAIL alu_fwd_a: got %0d required 1", bus.fwd_a); else n_pass++;
        n_total++; if (bus.fwd_b !== 3'd0) $display("FAIL alu_fwd_b: got %0d required 0", bus.fwd_b); else n_pass++;
        n_total++; if (bus.stall !== 1'b0) $display("FAIL alu_stall: got %0d required 0", bus.stall); else n_pass++;
        step();
        drive(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, K_ALU);
        #1;
        n_total++; if (bus.fwd_a !== 3'd2) $display("FAIL alu_p2_fwd_a: got %0d required 2", bus.fwd_a); else n_pass++;
        n_total++; if (bus.fwd_b !== 3'd1) $display("FAIL alu_p1_fwd_b: got %0d required 1", bus.fwd_b); else n_pass++;
        drain();
    endtask

    task automatic test_load_use();
        clear_cnt();
        drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, K_LD);
        step();
        drive(1'b1, 5'd0, 5'd3, 5'd8, 1'b1, K_ALU);
        #1;
        n_total++; if (bus.stall !== 1'b1) $display("FAIL load_c1_stall: got %0d required 1", bus.stall); else n_pass++;
        n_total++; if (bus.fwd_b !== 3'd0) $display("FAIL load_c1_fwd_b: got %0d required 0", bus.fwd_b); else n_pass++;
        step();
        n_total++; if (bus.stall !== 1'b0) $display("FAIL load_c2_stall: got %0d required 0", bus.stall); else n_pass++;
        n_total++; if (bus.fwd_b !== 3'd2) $display("FAIL load_c2_fwd_b: got %0d required 2", bus.fwd_b); else n_pass++;
        n_total++; if (bus.stall_cnt !== 4'd1) $display("FAIL load_cnt: got %0d required 1", bus.stall_cnt); else n_pass++;
        drain();
    endtask

    task automatic test_mul_use();
        clear_cnt();
        drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, K_MUL);
        step();
        drive(1'b1, 5'd9, 5'd9, 5'd14, 1'b1, K_ALU);
        for (int c = 0; c < MUL_LAT - 1; c++) begin
            #1;
            n_total++; if (bus.stall !== 1'b1) $display("FAIL mul_stall_c%0d: got %0d required 1", c, bus.stall); else n_pass++;
            step();
        end
        n_total++; if (bus.stall !== 1'b0) $display("FAIL mul_release_stall: got %0d required 0", bus.stall); else n_pass++;
        n_total++; if (bus.fwd_a !== 3'd4) $display("FAIL mul_fwd_a: got %0d required 4", bus.fwd_a); else n_pass++;
        n_total++; if (bus.fwd_b !== 3'd4) $display("FAIL mul_fwd_b: got %0d required 4", bus.fwd_b); else n_pass++;
        n_total++; if (bus.stall_cnt !== 4'd3) $display("FAIL mul_cnt: got %0d required 3", bus.stall_cnt); else n_pass++;
        drain();
    endtask

    task automatic test_priority();
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, K_ALU);
        step();
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, K_ALU);
        step();
        drive(1'b1, 5'd7, 5'd0, 5'd1, 1'b1, K_ALU);
        #1;
        n_total++; if (bus.fwd_a !== 3'd1) $display("FAIL youngest_fwd_a: got %0d required 1", bus.fwd_a); else n_pass++;
        drain();
        drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, K_ALU);
        step();
        drive(1'b1, 5'd4, 5'd0, 5'd0, 1'b1, K_ALU);
        #1;
        n_total++; if (bus.fwd_a !== 3'd0) $display("FAIL no_we_fwd_a: got %0d required 0", bus.fwd_a); else n_pass++;
        step();
        drive(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, K_ALU);
        #1;
        n_total++; if (bus.fwd_a !== 3'd0) $display("FAIL rd0_fwd_a: got %0d required 0", bus.fwd_a); else n_pass++;
        drain();
        drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, K_ALU);
        step();
        drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, K_LD);
        step();
        drive(1'b1, 5'd6, 5'd0, 5'd1, 1'b1, K_ALU);
        #1;
        n_total++; if (bus.stall !== 1'b1) $display("FAIL unready_young_stall: got %0d required 1", bus.stall); else n_pass++;
        n_total++; if (bus.fwd_a !== 3'd0) $display("FAIL unready_young_fwd_a: got %0d required 0", bus.fwd_a); else n_pass++;
        drain();
    endtask

    task automatic test_flush();
        clear_cnt();
        drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, K_LD);
        step();
        drive(1'b1, 5'd0, 5'd3, 5'd10, 1'b1, K_ALU);
        bus.flush = 1'b1;
        #1;
        n_total++; if (bus.stall !== 1'b0) $display("FAIL flush_stall: got %0d required 0", bus.stall); else n_pass++;
        step();
        bus.flush = 1'b0;
        drive(1'b1, 5'd10, 5'd3, 5'd12, 1'b1, K_ALU);
        #1;
        n_total++; if (bus.fwd_a !== 3'd0) $display("FAIL flush_bubble_fwd_a: got %0d required 0", bus.fwd_a); else n_pass++;
        n_total++; if (bus.fwd_b !== 3'd2) $display("FAIL flush_load_fwd_b: got %0d required 2", bus.fwd_b); else n_pass++;
        n_total++; if (bus.stall_cnt !== 4'd0) $display("FAIL flush_cnt: got %0d required 0", bus.stall_cnt); else n_pass++;
        drain();
        drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, K_LD);
        step();
        drive(1'b0, 5'd0, 5'd3, 5'd13, 1'b1, K_ALU);
        #1;
        n_total++; if (bus.stall !== 1'b0) $display("FAIL invalid_stall: got %0d required 0", bus.stall); else n_pass++;
        step();
        drive(1'b1, 5'd13, 5'd0, 5'd1, 1'b1, K_ALU);
        #1;
        n_total++; if (bus.fwd_a !== 3'd0) $display("FAIL invalid_bubble_fwd_a: got %0d required 0", bus.fwd_a); else n_pass++;
        n_total++; if (bus.stall_cnt !== 4'd0) $display("FAIL invalid_cnt: got %0d required 0", bus.stall_cnt); else n_pass++;
        drain();
    endtask

    task automatic test_reset_mid_stall();
        clear_cnt();
        drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, K_MUL);
        step();
        drive(1'b1, 5'd9, 5'd0, 5'd1, 1'b1, K_ALU);
        step();
        step();
        n_total++; if (bus.stall_cnt !== 4'd2) $display("FAIL midstall_cnt: got %0d required 2", bus.stall_cnt); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.stall !== 1'b0) $display("FAIL async_rst_stall: got %0d required 0", bus.stall); else n_pass++;
        n_total++; if (bus.fwd_a !== 3'd0) $display("FAIL async_rst_fwd_a: got %0d required 0", bus.fwd_a); else n_pass++;
        n_total++; if (bus.stall_cnt !== 4'd0) $display("FAIL async_rst_cnt: got %0d required 0", bus.stall_cnt); else n_pass++;
        #1;
        rst_n = 1'b1;
        drive(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, K_ALU);
        step();
        drive(1'b1, 5'd11, 5'd0, 5'd1, 1'b1, K_ALU);
        #1;
        n_total++; if (bus.fwd_a !== 3'd1) $display("FAIL post_rst_fwd_a: got %0d required 1", bus.fwd_a); else n_pass++;
        drain();
    endtask

    task automatic test_cnt_clr();
        clear_cnt();
        drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, K_MUL);
        step();
        drive(1'b1, 5'd9, 5'd0, 5'd1, 1'b1, K_ALU);
        step();
        n_total++; if (bus.stall_cnt !== 4'd1) $display("FAIL clr_pre_cnt: got %0d required 1", bus.stall_cnt); else n_pass++;
        bus.cnt_clr = 1'b1;
        #1;
        n_total++; if (bus.stall !== 1'b1) $display("FAIL clr_stall: got %0d required 1", bus.stall); else n_pass++;
        step();
        bus.cnt_clr = 1'b0;
        n_total++; if (bus.stall_cnt !== 4'd0) $display("FAIL clr_cnt: got %0d required 0", bus.stall_cnt); else n_pass++;
        step();
        n_total++; if (bus.stall_cnt !== 4'd1) $display("FAIL clr_resume_cnt: got %0d required 1", bus.stall_cnt); else n_pass++;
        n_total++; if (bus.stall !== 1'b0) $display("FAIL clr_end_stall: got %0d required 0", bus.stall); else n_pass++;
        drain();
    endtask

    task automatic test_saturation();
        clear_cnt();
        for (int r = 1; r <= 6; r++) begin
            drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, K_MUL);
            step();
            drive(1'b1, 5'd9, 5'd0, 5'd1, 1'b1, K_ALU);
            repeat (MUL_LAT - 1) step();
            if (r == 4) begin
                n_total++; if (bus.stall_cnt !== 4'd12) $display("FAIL sat_mid_cnt: got %0d required 12", bus.stall_cnt); else n_pass++;
            end
        end
        n_total++; if (bus.stall_cnt !== 4'd15) $display("FAIL sat_cnt: got %0d required 15", bus.stall_cnt); else n_pass++;
        drain();
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_mul_use();
        test_priority();
        test_flush();
        test_reset_mid_stall();
        test_cnt_clr();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
